// File: rtl/pal_pkg.sv
// Shared types and sizing helpers for the PAL fabric.
// Imported by the array top and its macrocells.
package pal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } cfg_state_t;

  localparam int REG_MODE_OFS = 0;
  localparam int INVERT_OFS   = 1;

  function automatic int cell_bits(
    input int num_inputs,
    input int num_terms
  );
    return num_terms * 2 * num_inputs + 2;
  endfunction

  function automatic int cfg_bits(
    input int num_inputs,
    input int num_terms,
    input int num_outputs
  );
    return num_outputs * cell_bits(num_inputs, num_terms);
  endfunction

endpackage

// File: rtl/pal_macrocell.sv
// One PAL output: AND terms over true/complement literals,
// OR, polarity XOR, output register and reg/comb select.
module pal_macrocell
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS = 5,
  parameter int NUM_TERMS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] a,
  input  logic [cell_bits(NUM_INPUTS, NUM_TERMS)-1:0] fuses,
  output logic                  y
);

  localparam int TB = 2 * NUM_INPUTS;
  localparam int MB = NUM_TERMS * TB;

  logic [TB-1:0]        lits;
  logic [NUM_TERMS-1:0] term;
  logic                 sum;
  logic                 pol;
  logic                 q;
  logic                 reg_mode;
  logic                 invert;

  assign lits     = {~a, a};
  assign reg_mode = fuses[MB + REG_MODE_OFS];
  assign invert   = fuses[MB + INVERT_OFS];

  // Unfused literals are forced to 1, so an empty mask yields 1.
  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    assign term[t] = &(lits | ~fuses[t*TB +: TB]);
  end

  assign sum = |term;
  assign pol = sum ^ invert;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= pol;
  end

  assign y = reg_mode ? q : pol;

endmodule

// File: rtl/pal_array.sv
// PAL array top: serial fuse loader with staged atomic commit
// feeding NUM_OUTPUTS macrocells.
module pal_array
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = 5,
  parameter int NUM_TERMS   = 4,
  parameter int NUM_OUTPUTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  A,
  output logic [NUM_OUTPUTS-1:0] Y,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_busy,
  output logic                   cfg_done
);

  localparam int CELL_BITS = cell_bits(NUM_INPUTS, NUM_TERMS);
  localparam int CFG_BITS  =
    cfg_bits(NUM_INPUTS, NUM_TERMS, NUM_OUTPUTS);
  localparam int CNT_W     = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_BITS - 1);

  cfg_state_t           state;
  cfg_state_t           nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CFG_BITS-1:0]  staging;
  logic [CFG_BITS-1:0]  active;
  logic                 accept;
  logic                 restart;

  // A start pulse during LOAD wins over a same-cycle valid bit.
  assign restart = cfg_start && (state != COMMIT);
  assign accept  = (state == LOAD) && !cfg_start && cfg_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (cfg_start) nxt = LOAD;
      LOAD:    if (accept && cnt == LAST) nxt = COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_busy = (state == LOAD) || (state == COMMIT);
    cfg_done = (state == COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      staging <= '0;
      active  <= '0;
    end else begin
      if (restart) begin
        cnt <= '0;
      end else if (accept) begin
        staging[cnt] <= cfg_bit;
        cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
      end
      if (state == COMMIT) active <= staging;
    end
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_cell
    pal_macrocell #(
      .NUM_INPUTS (NUM_INPUTS),
      .NUM_TERMS  (NUM_TERMS)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .a     (A),
      .fuses (active[o*CELL_BITS +: CELL_BITS]),
      .y     (Y[o])
    );
  end

endmodule

// File: tb/tb_pal_array.sv
// Directed bench for pal_array: reset state, comb/registered
// paths, gapped and restarted loads, and mid-load reset.
module tb_pal_array;

  localparam int NI  = 5;
  localparam int CFG = 84;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] A;
  logic [1:0]    Y;
  logic          cfg_start;
  logic          cfg_valid;
  logic          cfg_bit;
  logic          cfg_busy;
  logic          cfg_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  pal_array dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .Y         (Y),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (cfg_done === 1'b1) done_cnt++;

  // out0: term0 = A0&A1, terms1..3 = A4&~A4; out1 all zero
  function automatic logic [CFG-1:0] make_map(
    input logic rm,
    input logic inv
  );
    logic [CFG-1:0] v;
    v = '0;
    v[0] = 1'b1;
    v[1] = 1'b1;
    for (int t = 1; t < 4; t++) begin
      v[t*10 + 4] = 1'b1;
      v[t*10 + 9] = 1'b1;
    end
    v[40] = rm;
    v[41] = inv;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(
    input logic [CFG-1:0] v,
    input int lo,
    input int hi,
    input bit gap
  );
    for (int i = lo; i < hi; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = v[i];
      step();
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      if (gap) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    A = 5'b10101;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;
    #1;
    checks++;
    if (Y !== 2'b11) begin
      $display("FAIL reset_y got=%b exp=11", Y);
      failures++;
    end
    checks++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      $display("FAIL reset_flags busy=%b done=%b exp=0/0",
               cfg_busy, cfg_done);
      failures++;
    end
    step();
    rst = 1'b0;
    repeat (4) step();
    checks++;
    if (Y !== 2'b11 || cfg_busy !== 1'b0) begin
      $display("FAIL idle_after_reset y=%b busy=%b exp=11/0",
               Y, cfg_busy);
      failures++;
    end
    checks++;
    if (done_cnt !== 0) begin
      $display("FAIL idle_no_done got=%0d exp=0", done_cnt);
      failures++;
    end
  endtask

  task automatic test_comb();
    int d0;
    d0 = done_cnt;
    A = 5'b00011;
    start_load();
    send_bits(make_map(1'b0, 1'b0), 0, CFG, 1'b0);
    checks++;
    if (cfg_done !== 1'b1 || cfg_busy !== 1'b1) begin
      $display("FAIL commit_flags done=%b busy=%b exp=1/1",
               cfg_done, cfg_busy);
      failures++;
    end
    step();
    checks++;
    if (Y !== 2'b11 || cfg_done !== 1'b0) begin
      $display("FAIL comb_a00011 y=%b done=%b exp=11/0",
               Y, cfg_done);
      failures++;
    end
    A = 5'b00010;
    #1;
    checks++;
    if (Y !== 2'b10) begin
      $display("FAIL comb_a00010 got=%b exp=10", Y);
      failures++;
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL comb_done_count got=%0d exp=1",
               done_cnt - d0);
      failures++;
    end
  endtask

  task automatic test_reg_inv();
    start_load();
    send_bits(make_map(1'b1, 1'b1), 0, CFG, 1'b0);
    step();
    A = 5'b00011;
    step();
    checks++;
    if (Y !== 2'b10) begin
      $display("FAIL reg_inv_a00011 got=%b exp=10", Y);
      failures++;
    end
    A = 5'b00001;
    #1;
    checks++;
    if (Y !== 2'b10) begin
      $display("FAIL reg_latency got=%b exp=10", Y);
      failures++;
    end
    step();
    checks++;
    if (Y !== 2'b11) begin
      $display("FAIL reg_inv_a00001 got=%b exp=11", Y);
      failures++;
    end
    A = 5'b00011;
    step();
  endtask

  task automatic test_gapped();
    int d0;
    logic [CFG-1:0] v;
    d0 = done_cnt;
    v = make_map(1'b0, 1'b0);
    start_load();
    send_bits(v, 0, 42, 1'b1);
    checks++;
    if (Y !== 2'b10 || cfg_busy !== 1'b1) begin
      $display("FAIL gap_old_map y=%b busy=%b exp=10/1",
               Y, cfg_busy);
      failures++;
    end
    send_bits(v, 42, CFG - 1, 1'b1);
    checks++;
    if (done_cnt - d0 !== 0 || Y !== 2'b10) begin
      $display("FAIL gap_before_last done=%0d y=%b exp=0/10",
               done_cnt - d0, Y);
      failures++;
    end
    send_bits(v, CFG - 1, CFG, 1'b0);
    step();
    checks++;
    if (Y !== 2'b11) begin
      $display("FAIL gap_new_map got=%b exp=11", Y);
      failures++;
    end
    repeat (3) step();
    checks++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL gap_done_once got=%0d exp=1", done_cnt - d0);
      failures++;
    end
  endtask

  task automatic test_restart();
    int d0;
    logic [CFG-1:0] junk;
    d0 = done_cnt;
    junk = '1;
    start_load();
    send_bits(junk, 0, 40, 1'b0);
    checks++;
    if (cfg_busy !== 1'b1 || done_cnt - d0 !== 0) begin
      $display("FAIL restart_mid busy=%b done=%0d exp=1/0",
               cfg_busy, done_cnt - d0);
      failures++;
    end
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    send_bits(make_map(1'b0, 1'b1), 0, CFG, 1'b0);
    step();
    A = 5'b00011;
    #1;
    checks++;
    if (Y !== 2'b10) begin
      $display("FAIL restart_a00011 got=%b exp=10", Y);
      failures++;
    end
    A = 5'b00000;
    #1;
    checks++;
    if (Y !== 2'b11) begin
      $display("FAIL restart_a00000 got=%b exp=11", Y);
      failures++;
    end
    step();
    checks++;
    if (done_cnt - d0 !== 1) begin
      $display("FAIL restart_done_once got=%0d exp=1",
               done_cnt - d0);
      failures++;
    end
  endtask

  task automatic test_reset_midload();
    int d0;
    logic [CFG-1:0] v;
    v = make_map(1'b0, 1'b0);
    A = 5'b00010;
    start_load();
    send_bits(v, 0, 50, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      $display("FAIL midrst_flags busy=%b done=%b exp=0/0",
               cfg_busy, cfg_done);
      failures++;
    end
    checks++;
    if (Y !== 2'b11) begin
      $display("FAIL midrst_y got=%b exp=11", Y);
      failures++;
    end
    step();
    rst = 1'b0;
    step();
    d0 = done_cnt;
    start_load();
    send_bits(v, 0, CFG, 1'b0);
    step();
    checks++;
    if (Y !== 2'b10) begin
      $display("FAIL reload_a00010 got=%b exp=10", Y);
      failures++;
    end
    A = 5'b00011;
    #1;
    checks++;
    if (Y !== 2'b11 || done_cnt - d0 !== 1) begin
      $display("FAIL reload_a00011 y=%b done=%0d exp=11/1",
               Y, done_cnt - d0);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_comb();
    test_reg_inv();
    test_gapped();
    test_restart();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
